// File: rtl/demux_1_to_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_to_4_stream
// Purpose  : Buffered 1-to-4 stream demultiplexer. Each accepted word is
//            steered by in_sel into one of four per-channel FIFOs, and each
//            channel drains independently over its own valid/ready pair.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1_to_4_stream #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [3:0]         full
);

  // Pointer width addresses DEPTH entries; the count needs one more bit
  // so that it can represent DEPTH itself.
  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_CW    = $clog2(DEPTH) + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [3:0] w_full;
  logic       w_accept;

  // A full channel refuses input even if it is popping this cycle:
  // there is deliberately no pass-through path.
  assign in_ready = !w_full[in_sel];
  assign w_accept = in_valid && in_ready;
  assign full     = w_full;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr;
    logic [c_AW-1:0]  r_rd;
    logic [c_CW-1:0]  r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push     = w_accept && (in_sel == 2'(gi));
    assign w_pop      = out_valid[gi] && out_ready[gi];
    assign out_valid[gi] = (r_cnt != '0);
    assign w_full[gi]    = (r_cnt == c_DEPTH);
    assign out_data[gi*WIDTH +: WIDTH] = r_mem[r_rd];

    // Channel FIFO state: storage write, pointer advance and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          r_mem[k] <= '0;
        end
      end else begin
        if (w_push) begin
          r_mem[r_wr] <= in_data;
          r_wr        <= r_wr + 1'b1;
        end
        if (w_pop) begin
          r_rd <= r_rd + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_1_to_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1_to_4_stream
// Purpose  : Self-checking bench for demux_1_to_4_stream (WIDTH=4, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1_to_4_stream;

  localparam int W = 4;
  localparam int D = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [3:0]    full;

  int n_checks;
  int n_pass;

  demux_1_to_4_stream #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  data;
    logic        valid;
    logic [3:0]  ordy;
    logic        exp_rdy;  // in_ready before the edge
    logic [3:0]  exp_v;    // out_valid after the edge
    logic [3:0]  exp_f;    // full after the edge
    logic [15:0] exp_d;    // out_data after the edge, valid slices only
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slices of empty channels are don't-care and are zeroed before comparing.
  function automatic logic [15:0] masked(input logic [15:0] d, input logic [3:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (v[i]) r[i*4 +: 4] = d[i*4 +: 4];
    return r;
  endfunction

  initial begin
    int          sent;
    int          got;
    logic        push_now;
    logic [3:0]  gotw [$];

    n_checks = 0;
    n_pass   = 0;

    // Steering: one word per channel, consumers always ready.
    vecs[0]  = '{2'd0, 4'h3, 1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 16'h0003};
    vecs[1]  = '{2'd1, 4'hA, 1'b1, 4'b1111, 1'b1, 4'b0010, 4'b0000, 16'h00A0};
    vecs[2]  = '{2'd2, 4'h5, 1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0000, 16'h0500};
    vecs[3]  = '{2'd3, 4'hF, 1'b1, 4'b1111, 1'b1, 4'b1000, 4'b0000, 16'hF000};
    vecs[4]  = '{2'd3, 4'h0, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 16'h0000};
    // Backpressure and fill on channel 2.
    vecs[5]  = '{2'd2, 4'h1, 1'b1, 4'b0000, 1'b1, 4'b0100, 4'b0000, 16'h0100};
    vecs[6]  = '{2'd2, 4'h2, 1'b1, 4'b0000, 1'b1, 4'b0100, 4'b0100, 16'h0100};
    vecs[7]  = '{2'd2, 4'h3, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0100, 16'h0100};
    vecs[8]  = '{2'd0, 4'h3, 1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0100, 16'h0100};
    vecs[9]  = '{2'd2, 4'h3, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 16'h0200};
    vecs[10] = '{2'd2, 4'h3, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 16'h0300};
    vecs[11] = '{2'd2, 4'h3, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0000, 16'h0000};
    // Concurrent push/pop on channel 1.
    vecs[12] = '{2'd1, 4'h9, 1'b1, 4'b0000, 1'b1, 4'b0010, 4'b0000, 16'h0090};
    vecs[13] = '{2'd1, 4'h7, 1'b1, 4'b0010, 1'b1, 4'b0010, 4'b0000, 16'h0070};
    vecs[14] = '{2'd1, 4'h0, 1'b0, 4'b0010, 1'b1, 4'b0000, 4'b0000, 16'h0000};

    // Reset, idle.
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_full",      32'(full),      32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1;

    // Table-driven vectors.
    for (int v = 0; v < NV; v++) begin
      in_sel    = vecs[v].sel;
      in_data   = vecs[v].data;
      in_valid  = vecs[v].valid;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_v));
      chk($sformatf("v%0d_full", v),      32'(full),      32'(vecs[v].exp_f));
      chk($sformatf("v%0d_out_data", v),  32'(masked(out_data, out_valid)), 32'(vecs[v].exp_d));
    end

    // Wrap-around: 8 words through channel 3 with a toggling consumer.
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    in_sel    = 2'd3;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      out_ready[3] = cyc[0];
      in_valid     = (sent < 8);
      in_data      = sent[3:0];
      #1;
      push_now = in_valid && in_ready;
      if (out_valid[3] && out_ready[3]) begin
        gotw.push_back(out_data[15:12]);
        got++;
      end
      @(posedge clk);
      #1;
      if (push_now) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("wrap_count", 32'(got), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gotw.size()) chk($sformatf("wrap_word%0d", k), 32'(gotw[k]), 32'(k));
      else chk($sformatf("wrap_word%0d", k), 32'hFFFF_FFFF, 32'(k));
    end
    #1;
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // Reset mid-operation.
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h4;
    @(posedge clk); #1;
    in_sel = 2'd1; in_data = 4'h5;
    @(posedge clk); #1;
    in_sel = 2'd0; in_data = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sel   = 2'd0;
    #1;
    chk("prerst_out_valid", 32'(out_valid), 32'b0011);
    chk("prerst_full",      32'(full),      32'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_full",      32'(full),      32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_data",  32'(out_data),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst_out_valid_c%0d", c), 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
